// File: rtl/memory_controller_mc_if.sv
// Bus bundle for the polyphase FIR memory controller: frame input handshake,
// coefficient write port and the tap stream towards the MAC.
interface memory_controller_mc_if #(
    parameter int MAC_SIZE    = 255,
    parameter int COEFF_SIZE  = 16,
    parameter int SAMPLE_SIZE = 16,
    parameter int CH_NUM      = 2
);
    localparam int AW = (MAC_SIZE > 1) ? $clog2(MAC_SIZE) : 1;
    localparam int CW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    logic                          s_valid;
    logic                          s_ready;
    logic [CH_NUM*SAMPLE_SIZE-1:0] s_in;
    logic [CH_NUM-1:0]             ch_en;
    logic                          c_we;
    logic [AW-1:0]                 c_addr;
    logic [COEFF_SIZE-1:0]         c_in;
    logic [SAMPLE_SIZE-1:0]        s_out;
    logic [COEFF_SIZE-1:0]         c_out;
    logic                          mac_valid;
    logic                          mac_first;
    logic                          mac_last;
    logic [CW-1:0]                 mac_ch;
    logic                          busy;
    logic                          ovr;

    modport slave (
        input  s_valid, s_in, ch_en, c_we, c_addr, c_in,
        output s_ready, s_out, c_out, mac_valid, mac_first, mac_last, mac_ch, busy, ovr
    );

    modport master (
        output s_valid, s_in, ch_en, c_we, c_addr, c_in,
        input  s_ready, s_out, c_out, mac_valid, mac_first, mac_last, mac_ch, busy, ovr
    );
endinterface

// File: rtl/memory_controller_mc.sv
// Multi-channel sample/coefficient memory and tap sequencer for a polyphase
// FIR decimator. Keeps the last MAC_SIZE samples of every channel in ring
// buffers and, every D-th accepted frame, streams sample/coefficient pairs
// for each enabled channel in ascending channel order.
module memory_controller_mc #(
    parameter int MAC_SIZE    = 255,
    parameter int D           = 100,
    parameter int COEFF_SIZE  = 16,
    parameter int SAMPLE_SIZE = 16,
    parameter int CH_NUM      = 2
) (
    input logic                   clk,
    input logic                   nrst,
    memory_controller_mc_if.slave bus
);
    localparam int AW = (MAC_SIZE > 1) ? $clog2(MAC_SIZE) : 1;
    localparam int CW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int PW = (D > 1) ? $clog2(D) : 1;

    localparam logic [AW-1:0] K_LAST = AW'(MAC_SIZE - 1);
    localparam logic [AW-1:0] M_MOD  = AW'(MAC_SIZE);
    localparam logic [PW-1:0] P_LAST = PW'(D - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t state, state_next;

    logic [AW-1:0]     wr_ptr;
    logic [PW-1:0]     phase;
    logic [AW-1:0]     base;
    logic [CH_NUM-1:0] en_lat;
    logic [CW-1:0]     ch;
    logic [AW-1:0]     k;

    logic          mac_valid_q;
    logic          mac_first_q;
    logic          mac_last_q;
    logic [CW-1:0] mac_ch_q;

    logic          accept;
    logic          trigger;
    logic          coeff_wr;
    logic          in_run;
    logic [AW-1:0] saddr;
    logic [CW-1:0] first_ch;
    logic [CW-1:0] next_ch;
    logic          next_found;

    logic [SAMPLE_SIZE-1:0] bank_rd [CH_NUM];
    logic [COEFF_SIZE-1:0]  cmem [MAC_SIZE];
    logic [COEFF_SIZE-1:0]  c_rd;

    assign in_run      = (state == RUN);
    assign bus.s_ready = (state == IDLE) && !bus.c_we;
    assign accept      = bus.s_valid && bus.s_ready;
    assign trigger     = accept && (phase == P_LAST);
    assign coeff_wr    = (state == IDLE) && bus.c_we && (int'(bus.c_addr) < MAC_SIZE);
    assign bus.busy    = (state != IDLE);
    assign bus.ovr     = bus.s_valid && (state != IDLE);

    // Sample address walks backwards from the newest sample, wrapping at MAC_SIZE.
    assign saddr = (k > base) ? (base - k + M_MOD) : (base - k);

    // Lowest enabled channel of the frame being accepted starts the sequence.
    always_comb begin
        first_ch = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (bus.ch_en[i]) first_ch = CW'(i);
        end
    end

    // Next enabled channel strictly above the current one, if any.
    always_comb begin
        next_ch    = '0;
        next_found = 1'b0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (en_lat[i] && (i > int'(ch))) begin
                next_ch    = CW'(i);
                next_found = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic: an all-zero enable mask leaves the controller idle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (trigger && (bus.ch_en != '0)) state_next = RUN;
            RUN:     if ((k == K_LAST) && !next_found) state_next = DRAIN;
            DRAIN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Write pointer, decimation phase and tap/channel counters.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            phase  <= '0;
            base   <= '0;
            en_lat <= '0;
            ch     <= '0;
            k      <= '0;
        end else if (accept) begin
            wr_ptr <= (wr_ptr == K_LAST) ? '0 : wr_ptr + 1'b1;
            phase  <= (phase == P_LAST) ? '0 : phase + 1'b1;
            base   <= wr_ptr;
            en_lat <= bus.ch_en;
            ch     <= first_ch;
            k      <= '0;
        end else if (in_run) begin
            if (k == K_LAST) begin
                k  <= '0;
                ch <= next_ch;
            end else begin
                k <= k + 1'b1;
            end
        end
    end

    // One sample bank per channel; every channel is written on each accepted
    // frame so histories stay aligned even for disabled channels.
    for (genvar g = 0; g < CH_NUM; g++) begin : g_bank
        logic [SAMPLE_SIZE-1:0] mem [MAC_SIZE];
        logic [SAMPLE_SIZE-1:0] rd_q;

        // Sample ring write.
        always_ff @(posedge clk) begin
            if (accept) mem[wr_ptr] <= bus.s_in[g*SAMPLE_SIZE +: SAMPLE_SIZE];
        end

        // Registered sample read, one tap per RUN cycle.
        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst)       rd_q <= '0;
            else if (in_run) rd_q <= mem[saddr];
        end

        assign bank_rd[g] = rd_q;
    end

    // Coefficient table write, out-of-range addresses dropped.
    always_ff @(posedge clk) begin
        if (coeff_wr) cmem[bus.c_addr] <= bus.c_in;
    end

    // Registered coefficient read in lockstep with the sample read.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)       c_rd <= '0;
        else if (in_run) c_rd <= cmem[k];
    end

    // Tap flags delayed one cycle to line up with the RAM read data.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mac_valid_q <= 1'b0;
            mac_first_q <= 1'b0;
            mac_last_q  <= 1'b0;
            mac_ch_q    <= '0;
        end else begin
            mac_valid_q <= in_run;
            mac_first_q <= in_run && (k == '0);
            mac_last_q  <= in_run && (k == K_LAST);
            mac_ch_q    <= in_run ? ch : '0;
        end
    end

    assign bus.s_out     = bank_rd[mac_ch_q];
    assign bus.c_out     = c_rd;
    assign bus.mac_valid = mac_valid_q;
    assign bus.mac_first = mac_first_q;
    assign bus.mac_last  = mac_last_q;
    assign bus.mac_ch    = mac_ch_q;
endmodule

// File: tb/tb_memory_controller_mc.sv
// Scoreboard bench for memory_controller_mc: a frame-level model predicts the
// tap stream on each triggering frame, and a monitor checks every mac_valid beat.
module tb_memory_controller_mc;
    localparam int M   = 5;
    localparam int DD  = 3;
    localparam int CS  = 16;
    localparam int SS  = 16;
    localparam int CHN = 3;
    localparam int AW  = $clog2(M);

    typedef struct {
        int             ch;
        bit             first;
        bit             last;
        logic [SS-1:0]  s;
        bit             s_known;
        logic [CS-1:0]  c;
        bit             c_known;
    } beat_t;

    logic clk = 1'b0;
    logic nrst = 1'b0;

    memory_controller_mc_if #(.MAC_SIZE(M), .COEFF_SIZE(CS), .SAMPLE_SIZE(SS), .CH_NUM(CHN)) bus ();

    memory_controller_mc #(.MAC_SIZE(M), .D(DD), .COEFF_SIZE(CS), .SAMPLE_SIZE(SS), .CH_NUM(CHN)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    beat_t         sb[$];
    int            acc_cnt = 0;
    int            busy_rem = 0;
    logic [SS-1:0] smem_m [CHN][M];
    bit            sknown [CHN][M];
    logic [CS-1:0] coeff_m [M];
    bit            cknown [M];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [CHN*SS-1:0] randFrame();
        logic [CHN*SS-1:0] f;
        for (int c = 0; c < CHN; c++) f[c*SS +: SS] = SS'($urandom);
        return f;
    endfunction

    // Store the frame in the history; on every DD-th frame queue the taps.
    task automatic acceptFrame(input logic [CHN*SS-1:0] sin, input logic [CHN-1:0] en);
        int    pos;
        int    n;
        int    idx;
        beat_t b;
        pos = acc_cnt % M;
        for (int c = 0; c < CHN; c++) begin
            smem_m[c][pos] = sin[c*SS +: SS];
            sknown[c][pos] = 1'b1;
        end
        acc_cnt++;
        if ((acc_cnt % DD) == 0 && en != '0) begin
            n = 0;
            for (int c = 0; c < CHN; c++) begin
                if (en[c]) begin
                    n++;
                    for (int k = 0; k < M; k++) begin
                        idx       = (pos - k + M) % M;
                        b.ch      = c;
                        b.first   = (k == 0);
                        b.last    = (k == M - 1);
                        b.s       = smem_m[c][idx];
                        b.s_known = sknown[c][idx];
                        b.c       = coeff_m[k];
                        b.c_known = cknown[k];
                        sb.push_back(b);
                    end
                end
            end
            busy_rem = n * M + 1;
        end
    endtask

    task automatic applyStimulus(input bit sv, input logic [CHN*SS-1:0] sin, input logic [CHN-1:0] en,
                                 input bit cwe, input logic [AW-1:0] ca, input logic [CS-1:0] cin);
        bit exp_busy;
        @(negedge clk);
        bus.s_valid = sv;
        bus.s_in    = sin;
        bus.ch_en   = en;
        bus.c_we    = cwe;
        bus.c_addr  = ca;
        bus.c_in    = cin;
        #1;
        exp_busy = (busy_rem > 0);
        checkOutput("s_ready", 32'(bus.s_ready), 32'(!exp_busy && !cwe));
        checkOutput("busy", 32'(bus.busy), 32'(exp_busy));
        checkOutput("ovr", 32'(bus.ovr), 32'(sv && exp_busy));
        @(posedge clk);
        if (busy_rem > 0) begin
            busy_rem--;
        end else if (cwe) begin
            if (int'(ca) < M) begin
                coeff_m[ca] = cin;
                cknown[ca]  = 1'b1;
            end
        end else if (sv) begin
            acceptFrame(sin, en);
        end
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic waitDrained(input int limit);
        int n;
        n = 0;
        while ((busy_rem > 0 || sb.size() > 0) && n < limit) begin
            idleCycle();
            n++;
        end
        idleCycle();
        checkOutput("drain_pending_beats", 32'(sb.size()), 32'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_mac_valid"}, 32'(bus.mac_valid), 32'd0);
        checkOutput({tag, "_mac_first"}, 32'(bus.mac_first), 32'd0);
        checkOutput({tag, "_mac_last"}, 32'(bus.mac_last), 32'd0);
        checkOutput({tag, "_mac_ch"}, 32'(bus.mac_ch), 32'd0);
        checkOutput({tag, "_s_out"}, 32'(bus.s_out), 32'd0);
        checkOutput({tag, "_c_out"}, 32'(bus.c_out), 32'd0);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, "_ovr"}, 32'(bus.ovr), 32'd0);
        checkOutput({tag, "_s_ready"}, 32'(bus.s_ready), 32'd1);
    endtask

    // Monitor: every mac_valid beat must match the head of the scoreboard.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (nrst && bus.mac_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_beat: got mac_valid=1 expected 0 at %0t", $time);
                end else begin
                    b = sb.pop_front();
                    checkOutput("mac_ch", 32'(bus.mac_ch), 32'(b.ch));
                    checkOutput("mac_first", 32'(bus.mac_first), 32'(b.first));
                    checkOutput("mac_last", 32'(bus.mac_last), 32'(b.last));
                    if (b.s_known) checkOutput("s_out", 32'(bus.s_out), 32'(b.s));
                    if (b.c_known) checkOutput("c_out", 32'(bus.c_out), 32'(b.c));
                end
            end
        end
    end

    // Watchdog so a stuck run still ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r;
        bus.s_valid = 1'b0;
        bus.s_in    = '0;
        bus.ch_en   = '0;
        bus.c_we    = 1'b0;
        bus.c_addr  = '0;
        bus.c_in    = '0;

        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        nrst = 1'b1;

        $display("[TB] programming coefficients");
        for (int a = 0; a < M; a++) applyStimulus(1'b0, '0, '0, 1'b1, AW'(a), CS'($urandom));

        $display("[TB] c_we priority over a pending frame, out-of-range coefficient addresses");
        applyStimulus(1'b1, randFrame(), 3'b001, 1'b1, AW'(2), CS'($urandom));
        applyStimulus(1'b1, randFrame(), 3'b001, 1'b0, '0, '0);
        applyStimulus(1'b0, '0, '0, 1'b1, AW'(5), CS'($urandom));
        applyStimulus(1'b0, '0, '0, 1'b1, AW'(7), CS'($urandom));

        $display("[TB] zero enable mask, single high channel");
        for (int i = 0; i < DD; i++) applyStimulus(1'b1, randFrame(), 3'b000, 1'b0, '0, '0);
        for (int i = 0; i < DD && busy_rem == 0; i++) applyStimulus(1'b1, randFrame(), 3'b100, 1'b0, '0, '0);
        waitDrained(100);
        for (int i = 0; i < DD && busy_rem == 0; i++) applyStimulus(1'b1, randFrame(), 3'b010, 1'b0, '0, '0);
        waitDrained(100);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            applyStimulus(r < 70, randFrame(), CHN'($urandom_range(0, 7)),
                          r >= 92, AW'($urandom_range(0, 7)), CS'($urandom));
        end
        waitDrained(200);

        $display("[TB] reset during a running sequence");
        for (int i = 0; i < DD && busy_rem == 0; i++) applyStimulus(1'b1, randFrame(), 3'b111, 1'b0, '0, '0);
        repeat (4) applyStimulus(1'b1, randFrame(), 3'b111, 1'b0, '0, '0);
        #2;
        bus.s_valid = 1'b1;
        nrst = 1'b0;
        #1;
        checkAllZero("midrun_reset");
        sb.delete();
        busy_rem = 0;
        acc_cnt  = 0;
        @(negedge clk);
        bus.s_valid = 1'b0;
        nrst = 1'b1;

        $display("[TB] post-reset frames restart at slot 0");
        for (int i = 0; i < DD; i++) applyStimulus(1'b1, randFrame(), 3'b101, 1'b0, '0, '0);
        waitDrained(100);
        for (int i = 0; i < 2 * M; i++) applyStimulus(1'b1, randFrame(), 3'b001, 1'b0, '0, '0);
        waitDrained(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
